// File: rtl/uart_rx_fifo_if.sv
// Receive word stream: head-of-FIFO data, error tags and valid/ready.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 valid;
    logic                 ready;

    modport master (output data, parity_err, frame_err, valid, input ready);
    modport slave  (input data, parity_err, frame_err, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, configurable frame format
// and a first-word-fall-through output FIFO with per-word error tags.
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_i,
    uart_rx_fifo_if.master              m,
    output logic                        overrun_o,
    output logic                        break_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   stop1z_q, stop1z_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_d_q;
    logic                   decide, bit_v, par_exp, done;
    logic                   push, brk;
    logic [WW-1:0]          push_word;

    // Synchroniser idles high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            rxs_d_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rxs_d_q <= rxs;
        end
    end

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign bit_v   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign par_exp = (PARITY == 1) ? ~(^data_q) : ^data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            smp_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            stop1z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            smp_q    <= smp_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            stop1z_q <= stop1z_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        smp_d     = smp_q;
        data_d    = data_q;
        idx_d     = idx_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        stop1z_d  = stop1z_q;
        done      = 1'b0;
        push      = 1'b0;
        brk       = 1'b0;
        push_word = '0;
        decide    = (state_q != S_IDLE) && (cnt_q == CW'(H + 1));

        if (state_q != S_IDLE)
            cnt_d = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(H - 1)) smp_d[0] = rxs;
        if (cnt_q == CW'(H))     smp_d[1] = rxs;

        unique case (state_q)
            S_IDLE: begin
                if (rxs_d_q && !rxs) state_d = S_START;
            end
            S_START: begin
                if (decide) begin
                    state_d = bit_v ? S_IDLE : S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    data_d[idx_q] = bit_v;
                    idx_d         = idx_q + IW'(1);
                    if (idx_q == IW'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (decide) begin
                    if (bit_v != par_exp) perr_d = 1'b1;
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (decide) begin
                    stop1z_d = !bit_v;
                    if (!bit_v) ferr_d = 1'b1;
                    if (STOP_BITS == 2) state_d = S_STOP2;
                    else                done    = 1'b1;
                end
            end
            S_STOP2: begin
                if (decide) begin
                    if (!bit_v) ferr_d = 1'b1;
                    done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            push      = 1'b1;
            push_word = {perr_d, ferr_d, data_d};
            brk       = stop1z_d && (data_d == '0);
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            state_d   = S_IDLE;
        end
        if (state_d == S_IDLE) cnt_d = '0;
    end

    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          pop, full, wr, ovr_q, brk_q;
    logic [WW-1:0] head;

    // A full FIFO still takes a word when the head leaves in the same cycle
    assign pop     = (count_q != '0) && m.ready;
    assign full    = count_q == (AW+1)'(FIFO_DEPTH);
    assign wr      = push && (!full || pop);
    assign count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_q + AW'(wr);
            rptr_q  <= rptr_q + AW'(pop);
            count_q <= count_d;
            ovr_q   <= push && full && !pop;
            brk_q   <= brk;
        end
    end

    assign head         = mem_q[rptr_q];
    assign m.valid      = count_q != '0;
    assign m.data       = m.valid ? head[DATA_BITS-1:0] : '0;
    assign m.frame_err  = m.valid & head[DATA_BITS];
    assign m.parity_err = m.valid & head[DATA_BITS+1];
    assign overrun_o    = ovr_q;
    assign break_o      = brk_q;
    assign fifo_count_o = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receiver configurations (8N1, 8E1, 9N2) on a
// shared stimulus line, checking words, tags, overrun, break and reset.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    int   sel = 0;
    logic rdy_a = 1'b0, rdy_b = 1'b1, rdy_c = 1'b1;

    always #5 clk = ~clk;

    logic       rx_a, rx_b, rx_c;
    logic       ovr_o_a, brk_o_a, ovr_o_b, brk_o_b, ovr_o_c, brk_o_c;
    logic [4:0] cnt_a, cnt_b, cnt_c;

    assign rx_a = (sel == 0) ? rx : 1'b1;
    assign rx_b = (sel == 1) ? rx : 1'b1;
    assign rx_c = (sel == 2) ? rx : 1'b1;

    uart_rx_fifo_if #(.DATA_BITS(8)) ia ();
    uart_rx_fifo_if #(.DATA_BITS(8)) ib ();
    uart_rx_fifo_if #(.DATA_BITS(9)) ic ();

    assign ia.ready = rdy_a;
    assign ib.ready = rdy_b;
    assign ic.ready = rdy_c;

    uart_rx_fifo #(
        .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .rx_i(rx_a), .m(ia),
        .overrun_o(ovr_o_a), .break_o(brk_o_a), .fifo_count_o(cnt_a)
    );

    uart_rx_fifo #(
        .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .rx_i(rx_b), .m(ib),
        .overrun_o(ovr_o_b), .break_o(brk_o_b), .fifo_count_o(cnt_b)
    );

    uart_rx_fifo #(
        .DATA_BITS(9), .CLKS_PER_BIT(CPB), .PARITY(0),
        .STOP_BITS(2), .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut_c (
        .clk(clk), .rst(rst), .rx_i(rx_c), .m(ic),
        .overrun_o(ovr_o_c), .break_o(brk_o_c), .fifo_count_o(cnt_c)
    );

    int n_chk = 0;
    int n_err = 0;
    int ovr_a = 0;
    int brk_a = 0;
    logic [10:0] qa[$], qb[$], qc[$];

    // Record every accepted word as {perr, ferr, data9}
    always @(negedge clk) begin
        if (ia.valid && ia.ready) qa.push_back({ia.parity_err, ia.frame_err, 1'b0, ia.data});
        if (ib.valid && ib.ready) qb.push_back({ib.parity_err, ib.frame_err, 1'b0, ib.data});
        if (ic.valid && ic.ready) qc.push_back({ic.parity_err, ic.frame_err, ic.data});
        if (ovr_o_a) ovr_a++;
        if (brk_o_a) brk_a++;
    end

    function automatic logic [10:0] w(input logic p, input logic f, input logic [8:0] d);
        return {p, f, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic take(input int s, output logic [10:0] v);
        v = 'x;
        case (s)
            0: if (qa.size() > 0) v = qa.pop_front();
            1: if (qb.size() > 0) v = qb.pop_front();
            default: if (qc.size() > 0) v = qc.pop_front();
        endcase
    endtask

    task automatic mk(input logic [8:0] d, input int nd, input int pm, input logic pb,
                      input int ns, input logic sb, output logic [15:0] b, output int n);
        b    = '1;
        b[0] = 1'b0;
        n    = 1;
        for (int i = 0; i < nd; i++) begin
            b[n] = d[i];
            n++;
        end
        if (pm != 0) begin
            b[n] = pb;
            n++;
        end
        b[n] = sb;
        n++;
        if (ns == 2) begin
            b[n] = 1'b1;
            n++;
        end
    endtask

    // skew: 0 exact, +1 long bit first, -1 short bit first (alternating +/-1 cycle)
    // gb: frame bit that gets a 1-cycle inversion at mid-bit (-1 none)
    // pop_at/rst_at: stimulus cycle on which ready_a or rst is pulsed (-1 none)
    task automatic tx(input int s, input logic [8:0] d, input int nd, input int pm,
                      input logic pb, input int ns, input logic sb, input int skew,
                      input int gb, input int pop_at, input int rst_at);
        logic [15:0] b;
        int n;
        int t;
        int len;
        mk(d, nd, pm, pb, ns, sb, b, n);
        sel = s;
        t   = 0;
        for (int i = 0; i < n; i++) begin
            len = CPB;
            if (skew != 0) len = (((i % 2) == 0) == (skew > 0)) ? CPB + 1 : CPB - 1;
            for (int j = 0; j < len; j++) begin
                @(posedge clk);
                #1;
                rx = (i == gb && j == CPB / 2 + 1) ? ~b[i] : b[i];
                if (pop_at >= 0) rdy_a = (t == pop_at);
                if (t == rst_at) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    rx  = 1'b1;
                    return;
                end
                t++;
            end
        end
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            rx = 1'b1;
        end
    endtask

    task automatic drain_a();
        @(posedge clk);
        #1;
        rdy_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rdy_a = 1'b0;
        @(negedge clk);
    endtask

    logic [10:0] v;

    initial begin
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", ia.valid, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_data", ia.data, 0);
        chk("rst_perr", ia.parity_err, 0);
        chk("rst_ferr", ia.frame_err, 0);
        chk("rst_ovr", ovr_o_a, 0);
        chk("rst_brk", brk_o_a, 0);

        rdy_a = 1'b1;
        tx(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        chk("a5_n", qa.size(), 1);
        take(0, v);
        chk("a5_word", v, w(0, 0, 9'h0A5));
        chk("a5_count", cnt_a, 0);

        tx(1, 9'h053, 8, 1, 1'b1, 1, 1'b1, 0, -1, -1, -1);
        tx(1, 9'h053, 8, 1, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        chk("par_n", qb.size(), 2);
        take(1, v);
        chk("par_bad", v, w(1, 0, 9'h053));
        take(1, v);
        chk("par_good", v, w(0, 0, 9'h053));

        sel = 0;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("glitch_n", qa.size(), 0);
        chk("glitch_count", cnt_a, 0);

        tx(0, 9'h000, 8, 0, 1'b0, 1, 1'b0, 0, -1, -1, -1);
        chk("brk_n", qa.size(), 1);
        take(0, v);
        chk("brk_word", v, w(0, 1, 9'h000));
        chk("brk_pulses", brk_a, 1);
        tx(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        take(0, v);
        chk("after_brk", v, w(0, 0, 9'h03C));

        rdy_a = 1'b0;
        qa.delete();
        ovr_a = 0;
        for (int i = 1; i <= 17; i++)
            tx(0, 9'(i), 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        chk("full_count", cnt_a, 16);
        chk("ovr_pulses", ovr_a, 1);
        chk("head_hold", ia.data, 8'h01);
        drain_a();
        chk("drain_n", qa.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("drain_%0d", i), qa[i], w(0, 0, 9'(i + 1)));
        chk("drain_count", cnt_a, 0);

        qa.delete();
        ovr_a = 0;
        for (int i = 1; i <= 16; i++)
            tx(0, 9'(i), 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        tx(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 0, -1, 12 + CPB * 9, -1);
        chk("pp_ovr", ovr_a, 0);
        chk("pp_count", cnt_a, 16);
        chk("pp_popped", qa.size(), 1);
        qa.delete();
        drain_a();
        chk("pp_n", qa.size(), 16);
        chk("pp_first", qa[0], w(0, 0, 9'h002));
        chk("pp_last", qa[15], w(0, 0, 9'h011));

        tx(2, 9'h1A5, 9, 0, 1'b0, 2, 1'b1, 1, -1, -1, -1);
        tx(2, 9'h0F3, 9, 0, 1'b0, 2, 1'b1, -1, -1, -1, -1);
        tx(2, 9'h155, 9, 0, 1'b0, 2, 1'b1, 0, 4, -1, -1);
        chk("c_n", qc.size(), 3);
        take(2, v);
        chk("c_skew_p", v, w(0, 0, 9'h1A5));
        take(2, v);
        chk("c_skew_n", v, w(0, 0, 9'h0F3));
        take(2, v);
        chk("c_glitch", v, w(0, 0, 9'h155));

        qa.delete();
        tx(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        tx(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        tx(0, 9'h033, 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        chk("pre_rst_count", cnt_a, 3);
        tx(0, 9'h077, 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, CPB * 4 + 5);
        @(negedge clk);
        chk("mid_rst_count", cnt_a, 0);
        chk("mid_rst_valid", ia.valid, 0);
        repeat (10) @(posedge clk);
        #1;
        rdy_a = 1'b1;
        tx(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 0, -1, -1, -1);
        chk("post_rst_n", qa.size(), 1);
        take(0, v);
        chk("post_rst_word", v, w(0, 0, 9'h03C));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
